// File: rtl/eq_pkg.sv
// eq_pkg: shared constants, parser states and helpers for the luma remap path
package eq_pkg;
    localparam int XY_F = 6;
    localparam int XY_V = 5;
    localparam int XY_H = 4;
    localparam int XY_P = 7;
    localparam logic [7:0] ESC_FF = 8'hFF;
    localparam logic [7:0] ESC_00 = 8'h00;
    localparam int ACT_LEN_DEF = 1440;
    localparam logic [7:0] Y_MIN_DEF = 8'd16;
    localparam logic [7:0] Y_MAX_DEF = 8'd235;
    typedef enum logic [2:0] {ST_IDLE, ST_ESC1, ST_ESC2, ST_XY, ST_ACTIVE} pstate_e;
    typedef struct packed {
        logic luma;
        logic active;
        logic field;
    } flags_t;
    function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction
endpackage

// File: rtl/eq_lut_dpram.sv
// eq_lut_dpram: 2x256x8 simple dual-port table, write port plus registered read port
module eq_lut_dpram (
    input  logic       clk,
    input  logic       we,
    input  logic [8:0] waddr,
    input  logic [7:0] wdata,
    input  logic [8:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] mem_q [512];
    logic [7:0] rdata_q;
    // block-RAM style write and read-before-write registered read
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_q <= mem_q[raddr];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/eq_pixel_remap.sv
// eq_pixel_remap: parses BT.656 and remaps active luma through the equalisation table
module eq_pixel_remap
    import eq_pkg::*;
#(
    parameter int         ACT_LEN = ACT_LEN_DEF,
    parameter logic [7:0] Y_MIN   = Y_MIN_DEF,
    parameter logic [7:0] Y_MAX   = Y_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       config_done,
    input  logic [7:0] qd,
    input  logic       eq_en,
    input  logic       frame_sw,
    input  logic       lut_we,
    input  logic [9:0] lut_waddr,
    input  logic [7:0] lut_wdata,
    output logic [7:0] qd_out,
    output logic       active_out,
    output logic       field_out,
    output logic       err
);
    localparam int CW = $clog2(ACT_LEN + 1);

    pstate_e       state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    phase_q, phase_d;
    logic          f_q, f_d, rd_bank_q, rd_bank_d, err_q, err_d;
    logic [1:0]    valid_q, valid_d;
    logic [7:0]    qd_s1_q, qd_s1_d, qd_s2_q, qd_s2_d, qd_out_q, qd_out_d;
    flags_t        flg_s1, flg_s2_q, flg_s2_d;
    logic          bank_s2_q, bank_s2_d;
    logic          active_out_q, active_out_d, field_out_q, field_out_d;
    logic [7:0]    rdata;
    logic          at_end;

    assign at_end = count_q == CW'(ACT_LEN);

    eq_lut_dpram u_lut (
        .clk   (clk),
        .we    (lut_we && !lut_waddr[8]),
        .waddr ({lut_waddr[9], lut_waddr[7:0]}),
        .wdata (lut_wdata),
        .raddr ({rd_bank_q, qd_s1_q}),
        .rdata (rdata)
    );

    // parser state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            phase_q   <= '0;
            f_q       <= 1'b0;
            rd_bank_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            phase_q   <= phase_d;
            f_q       <= f_d;
            rd_bank_q <= rd_bank_d;
            err_q     <= err_d;
        end
    end

    // parser next state: walks FF 00 00 XY codes and counts active bytes
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        phase_d   = phase_q;
        f_d       = f_q;
        rd_bank_d = rd_bank_q;
        err_d     = err_q;
        if (!config_done) state_d = ST_IDLE;
        else begin
            unique case (state_q)
                ST_IDLE: state_d = (qd_s1_q == ESC_FF) ? ST_ESC1 : ST_IDLE;
                ST_ESC1: begin
                    state_d = (qd_s1_q == ESC_00) ? ST_ESC2 : ST_IDLE;
                    err_d   = err_q | (qd_s1_q != ESC_00);
                end
                ST_ESC2: begin
                    state_d = (qd_s1_q == ESC_00) ? ST_XY : ST_IDLE;
                    err_d   = err_q | (qd_s1_q != ESC_00);
                end
                ST_XY: begin
                    f_d       = qd_s1_q[XY_F];
                    rd_bank_d = qd_s1_q[XY_V] ? ~frame_sw : rd_bank_q;
                    err_d     = err_q | ~qd_s1_q[XY_P];
                    state_d   = (!qd_s1_q[XY_H] && !qd_s1_q[XY_V]) ? ST_ACTIVE : ST_IDLE;
                    count_d   = '0;
                    phase_d   = '0;
                end
                ST_ACTIVE: begin
                    if (qd_s1_q == ESC_FF) state_d = ST_ESC1;
                    else if (at_end) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                        phase_d = phase_q + 2'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // parser outputs: classify the stage-1 byte
    always_comb begin
        flg_s1.active = config_done && state_q == ST_ACTIVE && qd_s1_q != ESC_FF && !at_end;
        flg_s1.luma   = flg_s1.active && phase_q[0];
        flg_s1.field  = f_q;
    end

    // pipeline next values: S1 capture, S2 table read, S3 substitute and clamp
    always_comb begin
        qd_s1_d      = qd;
        qd_s2_d      = qd_s1_q;
        flg_s2_d     = flg_s1;
        bank_s2_d    = rd_bank_q;
        qd_out_d     = (flg_s2_q.luma && eq_en && valid_q[bank_s2_q]) ? clamp8(rdata, Y_MIN, Y_MAX) : qd_s2_q;
        active_out_d = flg_s2_q.active;
        field_out_d  = flg_s2_q.field;
        valid_d      = valid_q | ((lut_we && !lut_waddr[8] && &lut_waddr[7:0]) ? (2'b01 << lut_waddr[9]) : 2'b00);
    end

    // pipeline and bank-valid registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qd_s1_q      <= '0;
            qd_s2_q      <= '0;
            flg_s2_q     <= '0;
            bank_s2_q    <= 1'b0;
            qd_out_q     <= '0;
            active_out_q <= 1'b0;
            field_out_q  <= 1'b0;
            valid_q      <= '0;
        end else begin
            qd_s1_q      <= qd_s1_d;
            qd_s2_q      <= qd_s2_d;
            flg_s2_q     <= flg_s2_d;
            bank_s2_q    <= bank_s2_d;
            qd_out_q     <= qd_out_d;
            active_out_q <= active_out_d;
            field_out_q  <= field_out_d;
            valid_q      <= valid_d;
        end
    end

    assign qd_out     = qd_out_q;
    assign active_out = active_out_q;
    assign field_out  = field_out_q;
    assign err        = err_q;
endmodule

// File: tb/tb_eq_pixel_remap.sv
// tb_eq_pixel_remap: randomized scoreboard bench for the BT.656 luma remapper
module tb_eq_pixel_remap;
    localparam int ACT = 1440;

    typedef struct { int due; logic [7:0] q; logic a; logic f; } exp_t;
    typedef struct { int due; logic e; } erx_t;
    typedef struct { logic [9:0] a; logic [7:0] d; } wr_t;

    logic       clk = 1'b0, rst = 1'b1, config_done = 1'b1, eq_en = 1'b1, frame_sw = 1'b1, lut_we = 1'b0;
    logic [9:0] lut_waddr = '0;
    logic [7:0] lut_wdata = '0, qd = 8'h10;
    logic [7:0] qd_out;
    logic       active_out, field_out, err;

    eq_pixel_remap dut (
        .clk         (clk),
        .rst         (rst),
        .config_done (config_done),
        .qd          (qd),
        .eq_en       (eq_en),
        .frame_sw    (frame_sw),
        .lut_we      (lut_we),
        .lut_waddr   (lut_waddr),
        .lut_wdata   (lut_wdata),
        .qd_out      (qd_out),
        .active_out  (active_out),
        .field_out   (field_out),
        .err         (err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0, act_cnt = 0;
    exp_t sb[$];
    erx_t ev[$];
    wr_t  wq[$];

    // reference model: line-level view of the stream
    int         m_pos = -1, m_n = 0;
    bit         m_line = 0, m_fld = 0, m_bank = 0, m_err = 0;
    bit         m_valid [2] = '{0, 0};
    logic [7:0] tbl [2][256];
    bit         bt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: output appears 3 clk after its byte, err one clk earlier
    initial forever begin
        @(posedge clk);
        #1;
        if (sb.size() != 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if ({qd_out, active_out, field_out} !== {e.q, e.a, e.f}) begin
                n_bad++;
                $display("FAIL byte@%0d: got qd=%h act=%b fld=%b want qd=%h act=%b fld=%b", cyc, qd_out, active_out, field_out, e.q, e.a, e.f);
            end
            if (active_out) act_cnt++;
        end
        if (ev.size() != 0 && ev[0].due <= cyc) begin
            erx_t x;
            x = ev.pop_front();
            n_cmp++;
            if (err !== x.e) begin
                n_bad++;
                $display("FAIL err@%0d: got %b want %b", cyc, err, x.e);
            end
        end
    end

    function automatic logic [7:0] clampv(input logic [7:0] v);
        return (v < 8'd16) ? 8'd16 : ((v > 8'd235) ? 8'd235 : v);
    endfunction

    function automatic logic [7:0] xyb(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    function automatic logic [7:0] dat(input int mode, input int i);
        if (mode == 0) return (i % 4 == 1) ? 8'h10 : ((i % 4 == 3) ? 8'hC8 : 8'h80);
        if (mode == 1) return (i % 2 == 1) ? 8'h40 : 8'h80;
        return 8'($urandom_range(1, 254));
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic step(input logic [7:0] b);
        logic act, luma, f0, b0;
        logic [7:0] want;
        wr_t w;
        @(negedge clk);
        qd = b;
        lut_we = 1'b0;
        if (wq.size() != 0) begin
            w = wq.pop_front();
            lut_we = 1'b1;
            lut_waddr = w.a;
            lut_wdata = w.d;
        end
        f0 = m_fld;
        b0 = m_bank;
        act = 0;
        luma = 0;
        if (!config_done) begin
            m_pos = -1;
            m_line = 0;
        end else if (m_pos >= 0) begin
            m_pos++;
            if (m_pos < 3) begin
                if (b != 8'h00) begin
                    m_err = 1;
                    m_pos = -1;
                end
            end else begin
                m_fld = b[6];
                if (b[5]) m_bank = ~frame_sw;
                if (!b[7]) m_err = 1;
                m_line = !b[5] && !b[4];
                m_n = 0;
                m_pos = -1;
            end
        end else if (b == 8'hFF) begin
            m_pos = 0;
            m_line = 0;
        end else if (m_line) begin
            if (m_n == ACT) begin
                m_err = 1;
                m_line = 0;
            end else begin
                act = 1;
                luma = (m_n % 2 == 1);
                m_n++;
            end
        end
        want = (luma && eq_en && m_valid[b0]) ? clampv(tbl[b0][b]) : b;
        sb.push_back('{cyc + 3, want, act, f0});
        ev.push_back('{cyc + 2, m_err});
        if (lut_we && !lut_waddr[8]) begin
            tbl[lut_waddr[9]][lut_waddr[7:0]] = lut_wdata;
            if (&lut_waddr[7:0]) m_valid[lut_waddr[9]] = 1;
        end
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) begin
            step(bt ? 8'h10 : 8'h80);
            bt = ~bt;
        end
    endtask

    task automatic code(input logic [7:0] xy);
        step(8'hFF);
        step(8'h00);
        step(8'h00);
        step(xy);
    endtask

    task automatic load(input logic bk, input int mode, input int upto, input bit go);
        for (int i = 0; i <= upto; i++)
            wq.push_back('{{bk, 1'b0, 8'(i)}, (mode == 0) ? 8'(i) : ((mode == 1) ? 8'(255 - i) : 8'($urandom))});
        if (go) begin
            while (wq.size() != 0) blank(1);
            blank(4);
        end
    endtask

    task automatic line(input logic f, input int n, input int mode, input int sw_at, input bit eav);
        blank(8);
        code(xyb(f, 1'b1, 1'b0));
        blank(8);
        code(xyb(f, 1'b0, 1'b0));
        for (int i = 0; i < n; i++) begin
            if (i == sw_at) frame_sw = ~frame_sw;
            step(dat(mode, i));
        end
        if (eav) code(xyb(f, 1'b0, 1'b1));
        blank(8);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        qd = 8'h10;
        lut_we = 1'b0;
        wq.delete();
        #2 rst = 1'b0;
        #1;
        chk("rst_qd", 32'(qd_out), 0);
        chk("rst_act", 32'(active_out), 0);
        chk("rst_fld", 32'(field_out), 0);
        chk("rst_err", 32'(err), 0);
        sb.delete();
        ev.delete();
        m_pos = -1;
        m_line = 0;
        m_n = 0;
        m_fld = 0;
        m_bank = 0;
        m_err = 0;
        m_valid = '{0, 0};
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        apply_reset();
        blank(4);
        load(1'b0, 0, 255, 1);
        act_cnt = 0;
        line(1'b0, ACT, 0, -1, 1);
        chk("act_cnt", 32'(act_cnt), 32'(ACT));
        load(1'b0, 1, 255, 1);
        line(1'b0, ACT, 1, -1, 1);
        line(1'b1, ACT, 2, -1, 1);
        eq_en = 1'b0;
        line(1'b0, ACT, 2, -1, 1);
        eq_en = 1'b1;
        config_done = 1'b0;
        line(1'b1, ACT, 2, -1, 1);
        config_done = 1'b1;
        load(1'b1, 2, 255, 0);
        line(1'b0, ACT, 2, 800, 1);
        line(1'b0, ACT, 2, -1, 1);
        apply_reset();
        load(1'b0, 2, 254, 0);
        wq.push_back('{10'h1FF, 8'h00});
        while (wq.size() != 0) blank(1);
        line(1'b0, ACT, 2, -1, 1);
        frame_sw = 1'b1;
        blank(4);
        step(8'hFF);
        step(8'h00);
        step(8'h55);
        blank(8);
        chk("bad_err", 32'(err), 1);
        load(1'b0, 2, 255, 1);
        line(1'b1, 720, 2, -1, 1);
        blank(8);
        code(xyb(1'b0, 1'b1, 1'b0));
        code(xyb(1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 100; i++) step(dat(2, i));
        apply_reset();
        for (int i = 0; i < 200; i++) step(dat(2, i));
        blank(8);
        load(1'b0, 2, 255, 1);
        line(1'b1, ACT, 2, -1, 1);
        chk("resync_err", 32'(err), 0);
        apply_reset();
        load(1'b0, 2, 255, 1);
        line(1'b0, ACT + 1, 2, -1, 0);
        chk("ovf_err", 32'(err), 1);
        apply_reset();
        load(1'b0, 2, 255, 1);
        load(1'b1, 2, 255, 1);
        for (int k = 0; k < 6; k++) begin
            eq_en = ($urandom_range(0, 3) != 0);
            frame_sw = 1'($urandom);
            line(1'($urandom), $urandom_range(1, ACT / 2) * 2, 2, -1, 1);
        end
        blank(6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
